// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: registers EX/MEM, issues one data-memory access at a time, formats loads for WB.
// Optional macro LSU_MISALIGN_TRAP_EN adds o_misalign and turns misaligned halfword/word accesses into traps.
module riscv_lsu #(
    parameter int NB_WORD = 32,
    parameter int NB_ADDR = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_dmem_rd,
    input  logic               i_dmem_wr,
    input  logic [2:0]         i_funct3,
    input  logic [NB_WORD-1:0] i_addr,
    input  logic [NB_WORD-1:0] i_wdata,
    input  logic [4:0]         i_rd,
    input  logic               i_rf_wr,
    input  logic               i_wb_to_rf,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [3:0]         o_mem_be,
    output logic [NB_WORD-1:0] o_mem_wdata,
    input  logic               i_mem_ack,
    input  logic [NB_WORD-1:0] i_mem_rdata,
    output logic               o_wb_valid,
    output logic [4:0]         o_wb_rd,
    output logic               o_wb_rf_wr,
    output logic [NB_WORD-1:0] o_wb_data
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic               o_misalign
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state_r, state_nxt_s;
    logic [2:0]         funct3_r;
    logic [1:0]         lane_r;
    logic [4:0]         rd_r;
    logic               rf_wr_r;
    logic [NB_WORD-1:0] pass_r;
    logic               mem_op_s, is_store_s, reserved_s, trap_s, issue_s;
    logic               unused_s;

    function automatic logic [3:0] calc_be(input logic is_store, input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b1111;
        if (is_store) begin
            case (f3[1:0])
                2'b00:   be = 4'b0001 << a;
                2'b01:   be = 4'b0011 << {a[1], 1'b0};
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic [NB_WORD-1:0] store_data(input logic [2:0] f3, input logic [NB_WORD-1:0] wd);
        logic [NB_WORD-1:0] d;
        case (f3[1:0])
            2'b00:   d = {(NB_WORD/8){wd[7:0]}};
            2'b01:   d = {(NB_WORD/16){wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Halfword lane uses only a[1], so a misaligned halfword is silently aligned.
    function automatic logic [NB_WORD-1:0] load_data(input logic [2:0] f3, input logic [1:0] a,
                                                     input logic [NB_WORD-1:0] rd);
        logic [7:0]         b;
        logic [15:0]        h;
        logic [NB_WORD-1:0] d;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  d = {{(NB_WORD-8){b[7]}}, b};
            3'b001:  d = {{(NB_WORD-16){h[15]}}, h};
            3'b100:  d = {{(NB_WORD-8){1'b0}}, b};
            3'b101:  d = {{(NB_WORD-16){1'b0}}, h};
            default: d = rd;
        endcase
        return d;
    endfunction

    assign o_ready    = (state_r == IDLE);
    assign mem_op_s   = i_dmem_rd | i_dmem_wr;
    assign is_store_s = i_dmem_wr;
    assign reserved_s = is_store_s ? (i_funct3[2] | (i_funct3[1:0] == 2'b11))
                                   : ((i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11));
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_s = mem_op_s & ~reserved_s &
                    (((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                     ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00)));
`else
    assign trap_s = 1'b0;
`endif
    assign issue_s  = mem_op_s & ~reserved_s & ~trap_s;
    assign unused_s = i_wb_to_rf;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_valid && issue_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (i_mem_ack) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Memory request, saved context and MEM/WB registers
    always_ff @(posedge clk) begin
        if (rst) begin
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= {NB_ADDR{1'b0}};
            o_mem_be    <= 4'b0000;
            o_mem_wdata <= {NB_WORD{1'b0}};
            o_wb_valid  <= 1'b0;
            o_wb_rd     <= 5'd0;
            o_wb_rf_wr  <= 1'b0;
            o_wb_data   <= {NB_WORD{1'b0}};
            funct3_r    <= 3'd0;
            lane_r      <= 2'd0;
            rd_r        <= 5'd0;
            rf_wr_r     <= 1'b0;
            pass_r      <= {NB_WORD{1'b0}};
`ifdef LSU_MISALIGN_TRAP_EN
            o_misalign  <= 1'b0;
`endif
        end else begin
            o_wb_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            o_misalign <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (i_valid && issue_s) begin
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= is_store_s;
                        o_mem_addr  <= {i_addr[NB_ADDR-1:2], 2'b00};
                        o_mem_be    <= calc_be(is_store_s, i_funct3, i_addr[1:0]);
                        o_mem_wdata <= store_data(i_funct3, i_wdata);
                        funct3_r    <= i_funct3;
                        lane_r      <= i_addr[1:0];
                        rd_r        <= i_rd;
                        rf_wr_r     <= i_rf_wr;
                        pass_r      <= i_addr;
                    end else if (i_valid) begin
                        o_wb_valid <= 1'b1;
                        o_wb_data  <= i_addr;
                        o_wb_rd    <= i_rd;
                        o_wb_rf_wr <= i_rf_wr & ~mem_op_s;
`ifdef LSU_MISALIGN_TRAP_EN
                        o_misalign <= trap_s;
`endif
                    end
                end
                BUSY: begin
                    if (i_mem_ack) begin
                        o_mem_req  <= 1'b0;
                        o_wb_valid <= 1'b1;
                        o_wb_rd    <= rd_r;
                        if (o_mem_we) begin
                            o_wb_data  <= pass_r;
                            o_wb_rf_wr <= 1'b0;
                        end else begin
                            o_wb_data  <= load_data(funct3_r, lane_r, i_mem_rdata);
                            o_wb_rf_wr <= rf_wr_r;
                        end
                    end
                end
                default: o_mem_req <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized self-checking bench for riscv_lsu against a transaction-level reference model.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, o_ready, i_dmem_rd, i_dmem_wr;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic [4:0]  i_rd;
    logic        i_rf_wr, i_wb_to_rf;
    logic        o_mem_req, o_mem_we;
    logic [15:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic        o_wb_rf_wr;
    logic [31:0] o_wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        o_misalign;
`endif

    always #5 clk = ~clk;

    riscv_lsu #(.NB_WORD(32), .NB_ADDR(16)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_dmem_rd(i_dmem_rd), .i_dmem_wr(i_dmem_wr), .i_funct3(i_funct3),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd), .i_rf_wr(i_rf_wr),
        .i_wb_to_rf(i_wb_to_rf), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_wb_valid(o_wb_valid),
        .o_wb_rd(o_wb_rd), .o_wb_rf_wr(o_wb_rf_wr), .o_wb_data(o_wb_data)
`ifdef LSU_MISALIGN_TRAP_EN
        , .o_misalign(o_misalign)
`endif
    );

    typedef struct packed {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] wbdata;
        logic        rfwr;
        logic        mis;
    } pred_t;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs just after the next rising edge
    logic        e_chk = 1'b0, e_zero = 1'b0;
    logic        e_ready, e_req, e_we, e_wbv, e_rfwr, e_mis;
    logic [15:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_wbdata;
    logic [4:0]  e_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the LSU must do with one instruction, from the ISA size/sign rules.
    function automatic pred_t predict(input logic rdop, input logic wrop, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [31:0] rdata, input logic rfwr);
        pred_t       p;
        int          nbytes, off;
        logic [31:0] v, mask;
        logic        ok;
        p = '0;
        p.wbdata = addr;
        if (!rdop && !wrop) begin
            p.rfwr = rfwr;
            return p;
        end
        ok = wrop ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!ok) return p;
        nbytes = 1 << f3[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        if ((int'(addr[1:0]) % nbytes) != 0) begin
            p.mis = 1'b1;
            return p;
        end
`endif
        off    = (int'(addr[1:0]) / nbytes) * nbytes;
        p.req  = 1'b1;
        p.we   = wrop;
        p.addr = addr[15:0] & 16'hFFFC;
        if (wrop) begin
            p.be = 4'(((1 << nbytes) - 1) << off);
            for (int k = 0; k < 4; k++) p.wdata[8*k +: 8] = wdata[8*(k % nbytes) +: 8];
        end else begin
            p.be = 4'hF;
            v = rdata >> (8 * off);
            if (nbytes < 4) begin
                mask = (32'h1 << (8 * nbytes)) - 32'h1;
                v = v & mask;
                if (!f3[2] && v[8*nbytes-1]) v = v | ~mask;
            end
            p.wbdata = v;
            p.rfwr   = rfwr;
        end
        return p;
    endfunction

    // Compare process: one sample 1 time unit after every rising edge
    always @(posedge clk) begin
        #1;
        if (e_chk) begin
            chk("ready", 32'(o_ready), 32'(e_ready));
            chk("mem_req", 32'(o_mem_req), 32'(e_req));
            chk("wb_valid", 32'(o_wb_valid), 32'(e_wbv));
`ifdef LSU_MISALIGN_TRAP_EN
            chk("misalign", 32'(o_misalign), 32'(e_mis));
`endif
            if (e_req) begin
                chk("mem_we", 32'(o_mem_we), 32'(e_we));
                chk("mem_addr", 32'(o_mem_addr), 32'(e_addr));
                chk("mem_be", 32'(o_mem_be), 32'(e_be));
                if (e_we) chk("mem_wdata", o_mem_wdata, e_wdata);
            end
            if (e_wbv) begin
                chk("wb_data", o_wb_data, e_wbdata);
                chk("wb_rd", 32'(o_wb_rd), 32'(e_rd));
                chk("wb_rf_wr", 32'(o_wb_rf_wr), 32'(e_rfwr));
            end
            if (e_zero) begin
                chk("rst_mem_we", 32'(o_mem_we), 32'd0);
                chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
                chk("rst_mem_be", 32'(o_mem_be), 32'd0);
                chk("rst_mem_wdata", o_mem_wdata, 32'd0);
                chk("rst_wb_data", o_wb_data, 32'd0);
                chk("rst_wb_rd", 32'(o_wb_rd), 32'd0);
                chk("rst_wb_rf_wr", 32'(o_wb_rf_wr), 32'd0);
            end
        end
    end

    task automatic junk_inputs(input logic valid);
        i_valid    = valid;
        i_dmem_rd  = 1'($urandom);
        i_dmem_wr  = 1'($urandom);
        i_funct3   = 3'($urandom);
        i_addr     = $urandom;
        i_wdata    = $urandom;
        i_rd       = 5'($urandom);
        i_rf_wr    = 1'($urandom);
        i_wb_to_rf = 1'($urandom);
    endtask

    task automatic idle_expect();
        e_ready = 1'b1; e_req = 1'b0; e_wbv = 1'b0; e_mis = 1'b0;
    endtask

    // One instruction; d = BUSY cycles before the ack cycle (0 = ack in first BUSY cycle)
    task automatic run_txn(input logic rdop, input logic wrop, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                           input logic [4:0] rd, input logic rfwr, input int d, output pred_t p);
        @(negedge clk);
        i_valid = 1'b1; i_dmem_rd = rdop; i_dmem_wr = wrop; i_funct3 = f3;
        i_addr = addr; i_wdata = wdata; i_rd = rd; i_rf_wr = rfwr; i_wb_to_rf = 1'($urandom);
        i_mem_rdata = rdata;
        i_mem_ack = 1'($urandom);
        p = predict(rdop, wrop, f3, addr, wdata, rdata, rfwr);
        e_zero = 1'b0;
        if (p.req) begin
            e_ready = 1'b0; e_req = 1'b1; e_wbv = 1'b0; e_mis = 1'b0;
            e_we = p.we; e_addr = p.addr; e_be = p.be; e_wdata = p.wdata;
            for (int i = 0; i <= d; i++) begin
                @(negedge clk);
                junk_inputs(1'($urandom));
                i_mem_rdata = rdata;
                i_mem_ack   = (i == d);
                if (i == d) begin
                    e_ready = 1'b1; e_req = 1'b0; e_wbv = 1'b1;
                    e_wbdata = p.wbdata; e_rd = rd; e_rfwr = p.rfwr;
                end
            end
        end else begin
            e_ready = 1'b1; e_req = 1'b0; e_wbv = 1'b1; e_mis = p.mis;
            e_wbdata = p.wbdata; e_rd = rd; e_rfwr = p.rfwr;
        end
        @(negedge clk);
        junk_inputs(1'b0);
        i_mem_ack = 1'($urandom);
        idle_expect();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        pred_t p;
        rst = 1'b1;
        junk_inputs(1'b0);
        i_mem_ack = 1'b0;
        i_mem_rdata = 32'd0;
        idle_expect();
        @(negedge clk);
        e_chk = 1'b1; e_zero = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // SB to byte 3, ack in first BUSY cycle
        run_txn(1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_00AB, 32'h0, 5'd7, 1'b1, 0, p);
        chk("pin_sb_be", 32'(p.be), 32'h8);
        chk("pin_sb_wdata", p.wdata, 32'hABAB_ABAB);
        chk("pin_sb_rfwr", 32'(p.rfwr), 32'd0);
        // LB / LBU from lane 2
        run_txn(1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h12F4_5678, 5'd3, 1'b1, 1, p);
        chk("pin_lb", p.wbdata, 32'hFFFF_FFF4);
        run_txn(1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h12F4_5678, 5'd3, 1'b1, 2, p);
        chk("pin_lbu", p.wbdata, 32'h0000_00F4);
        // LH with three wait cycles
        run_txn(1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'h0, 32'h8001_0000, 5'd9, 1'b1, 3, p);
        chk("pin_lh", p.wbdata, 32'hFFFF_8001);
        // Non-memory passthrough
        run_txn(1'b0, 1'b0, 3'b010, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd5, 1'b1, 0, p);
        chk("pin_alu", p.wbdata, 32'hDEAD_BEEF);
        chk("pin_alu_req", 32'(p.req), 32'd0);
        // Misaligned LW
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 5'd1, 1'b1, 0, p);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("pin_lw_mis", 32'(p.mis), 32'd1);
        chk("pin_lw_mis_req", 32'(p.req), 32'd0);
`else
        chk("pin_lw_addr", 32'(p.addr), 32'h0004);
        chk("pin_lw_be", 32'(p.be), 32'hF);
`endif
        // Reserved store encoding
        run_txn(1'b0, 1'b1, 3'b101, 32'h0000_0020, 32'h1234_5678, 32'h0, 5'd2, 1'b1, 0, p);
        chk("pin_rsv_req", 32'(p.req), 32'd0);

        // Reset in the second BUSY cycle, late ack one cycle after
        @(negedge clk);
        i_valid = 1'b1; i_dmem_rd = 1'b1; i_dmem_wr = 1'b0; i_funct3 = 3'b010;
        i_addr = 32'h0000_0040; i_rd = 5'd4; i_rf_wr = 1'b1; i_mem_ack = 1'b0;
        p = predict(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 1'b1);
        e_ready = 1'b0; e_req = 1'b1; e_wbv = 1'b0; e_we = p.we; e_addr = p.addr; e_be = p.be;
        @(negedge clk);
        junk_inputs(1'b1);
        i_mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle_expect();
        e_zero = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        junk_inputs(1'b0);
        i_mem_ack = 1'b1;
        @(negedge clk);
        i_mem_ack = 1'b0;
        e_zero = 1'b0;

        // Randomized instructions
        for (int n = 0; n < 300; n++) begin
            logic [1:0] kind;
            kind = 2'($urandom);
            run_txn(kind[0], kind[1], 3'($urandom), $urandom, $urandom, $urandom,
                    5'($urandom), 1'($urandom), int'($urandom_range(0, 3)), p);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
